// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_e;

  // Bits needed to count down from n-1 to 0; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract the divisor.
module div_restore_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign r_shift = {rem, next_bit};
  assign borrow  = r_shift < {1'b0, b};
  // Without borrow the true difference is below b, so the low WIDTH bits are exact.
  assign diff    = r_shift[WIDTH-1:0] - b;
  assign q_bit   = ~borrow;
  assign new_rem = borrow ? r_shift[WIDTH-1:0] : diff;

endmodule

// File: rtl/seq_div_rem.sv
// Multi-cycle unsigned divider: one quotient bit per clock, valid/ready on both sides.
module seq_div_rem
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] REM,
  output logic             DBZ
);

  localparam int unsigned       CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, rem_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] c_q, rem_out_q;
  logic             dbz_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] q_next;
  logic             calc_last;

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .next_bit(q_q[WIDTH-1]),
    .b       (b_q),
    .new_rem (step_rem),
    .q_bit   (step_bit)
  );

  // Dividend bits shift out the top while quotient bits shift in the bottom.
  if (WIDTH == 1) begin : g_q_one
    assign q_next = step_bit;
  end else begin : g_q_wide
    assign q_next = {q_q[WIDTH-2:0], step_bit};
  end

  assign calc_last = (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (IN_VALID) state_d = (B == '0) ? DIV_DONE : DIV_CALC;
      end
      DIV_CALC: begin
        if (calc_last) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (OUT_READY) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state_q == DIV_IDLE) && !RST;
    OUT_VALID = (state_q == DIV_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q       <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      c_q       <= '0;
      rem_out_q <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (IN_VALID) begin
            b_q <= B;
            if (B == '0) begin
              c_q       <= '1;
              rem_out_q <= A;
              dbz_q     <= 1'b1;
            end else begin
              q_q   <= A;
              rem_q <= '0;
              cnt_q <= CNT_LAST;
            end
          end
        end
        DIV_CALC: begin
          q_q   <= q_next;
          rem_q <= step_rem;
          if (calc_last) begin
            c_q       <= q_next;
            rem_out_q <= step_rem;
            dbz_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign C   = c_q;
  assign REM = rem_out_q;
  assign DBZ = dbz_q;

endmodule

// File: tb/tb_seq_div_rem.sv
// Self-checking bench for seq_div_rem at WIDTH 4, 8 and 1 against an arithmetic reference.
module tb_seq_div_rem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH=4 instance
  logic       rst4 = 1'b1, iv4 = 1'b0, or4 = 1'b0;
  logic       ir4, ov4, z4;
  logic [3:0] a4 = '0, b4 = '0, c4, r4;
  // WIDTH=8 instance
  logic       rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b0;
  logic       ir8, ov8, z8;
  logic [7:0] a8 = '0, b8 = '0, c8, r8;
  // WIDTH=1 instance
  logic       rst1 = 1'b1, iv1 = 1'b0, or1 = 1'b0;
  logic       ir1, ov1, z1;
  logic [0:0] a1 = '0, b1 = '0, c1, r1;

  seq_div_rem #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst4), .IN_VALID(iv4), .IN_READY(ir4), .A(a4), .B(b4),
    .OUT_VALID(ov4), .OUT_READY(or4), .C(c4), .REM(r4), .DBZ(z4)
  );
  seq_div_rem #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst8), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
    .OUT_VALID(ov8), .OUT_READY(or8), .C(c8), .REM(r8), .DBZ(z8)
  );
  seq_div_rem #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst1), .IN_VALID(iv1), .IN_READY(ir1), .A(a1), .B(b1),
    .OUT_VALID(ov1), .OUT_READY(or1), .C(c1), .REM(r1), .DBZ(z1)
  );

  typedef struct {
    int c;
    int rem;
    int dbz;
  } result_t;

  // Reference: floor division and modulo; divide-by-zero gives all-ones and the dividend.
  function automatic result_t model(input int w, input int a, input int b);
    result_t r;
    if (b == 0) begin
      r.c = (1 << w) - 1; r.rem = a; r.dbz = 1;
    end else begin
      r.c = a / b; r.rem = a % b; r.dbz = 0;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op to dut4 and count edges after the capture edge until OUT_VALID.
  task automatic run4(input int a, input int b, output int lat);
    int n;
    n = 0;
    while (!ir4 && n < 40) begin tick(); n++; end
    a4 = 4'(a); b4 = 4'(b); iv4 = 1'b1;
    tick();
    iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 0;
    while (!ov4 && lat < 40) begin tick(); lat++; end
  endtask

  task automatic check4(input string name, input int a, input int b, input int lat);
    result_t e;
    int      exp_lat;
    e = model(4, a, b);
    exp_lat = (b == 0) ? 0 : 4;
    checks++;
    if (ov4 !== 1'b1 || lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: out_valid=%b after %0d edges, required 1 after %0d",
               name, ov4, lat, exp_lat);
    end
    checks++;
    if (c4 !== 4'(e.c) || r4 !== 4'(e.rem) || z4 !== 1'(e.dbz)) begin
      errors++;
      $display("FAIL %s_result: %0d/%0d got C=%0d REM=%0d DBZ=%b, required C=%0d REM=%0d DBZ=%0d",
               name, a, b, c4, r4, z4, e.c, e.rem, e.dbz);
    end
  endtask

  task automatic release4(input string name);
    or4 = 1'b1;
    tick();
    or4 = 1'b0;
    checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 and 1", name, ov4, ir4);
    end
  endtask

  task automatic test_reset;
    rst4 = 1'b1; rst8 = 1'b1; rst1 = 1'b1;
    tick(); tick();
    checks++;
    if (ir4 !== 1'b0 || ov4 !== 1'b0 || c4 !== 4'd0 || r4 !== 4'd0 || z4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b C=%0d REM=%0d DBZ=%b, required all 0",
               ir4, ov4, c4, r4, z4);
    end
    rst4 = 1'b0; rst8 = 1'b0; rst1 = 1'b0;
    #1;
    checks++;
    if (ir4 !== 1'b1 || ir8 !== 1'b1 || ir1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready w4=%b w8=%b w1=%b, required 1", ir4, ir8, ir1);
    end
  endtask

  task automatic test_basic;
    int lat;
    run4(13, 4, lat);
    check4("basic_13_4", 13, 4, lat);
    release4("basic");
  endtask

  task automatic test_div_by_zero;
    int lat;
    run4(7, 0, lat);
    check4("dbz_7_0", 7, 0, lat);
    release4("dbz");
  endtask

  task automatic test_corners;
    int pa[6] = '{15, 0, 3, 9, 14, 15};
    int pb[6] = '{1, 5, 9, 3, 15, 0};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run4(pa[i], pb[i], lat);
      check4("corner", pa[i], pb[i], lat);
      release4("corner");
    end
  endtask

  task automatic test_stall;
    int lat;
    run4(13, 4, lat);
    check4("stall_13_4", 13, 4, lat);
    for (int i = 0; i < 10; i++) begin
      iv4 = 1'b1; a4 = 4'd2; b4 = 4'd1;
      tick();
      checks++;
      if (ov4 !== 1'b1 || c4 !== 4'd3 || r4 !== 4'd1 || z4 !== 1'b0 || ir4 !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d out_valid=%b C=%0d REM=%0d DBZ=%b in_ready=%b, %s",
                 i, ov4, c4, r4, z4, ir4, "required 1 3 1 0 0");
      end
    end
    iv4 = 1'b0;
    release4("stall");
  endtask

  task automatic test_abort;
    int  lat;
    logic seen;
    a4 = 4'd13; b4 = 4'd4; iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ov4) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0 || c4 !== 4'd0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid seen=%b C=%0d, required 0 and 0", seen, c4);
    end
    run4(10, 3, lat);
    check4("abort_next_10_3", 10, 3, lat);
    release4("abort");
  endtask

  task automatic test_width1;
    result_t e;
    int      lat, exp_lat;
    for (int a = 0; a < 2; a++) begin
      for (int b = 0; b < 2; b++) begin
        e = model(1, a, b);
        exp_lat = (b == 0) ? 0 : 1;
        a1 = 1'(a); b1 = 1'(b); iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin tick(); lat++; end
        checks++;
        if (ov1 !== 1'b1 || lat != exp_lat || c1 !== 1'(e.c) || r1 !== 1'(e.rem)
            || z1 !== 1'(e.dbz)) begin
          errors++;
          $display("FAIL width1: %0d/%0d lat=%0d C=%0d REM=%0d DBZ=%b, required %0d %0d %0d %0d",
                   a, b, lat, c1, r1, z1, exp_lat, e.c, e.rem, e.dbz);
        end
        or1 = 1'b1;
        tick();
        or1 = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    result_t q[$];
    result_t e;
    int      done, cycles;
    done = 0;
    cycles = 0;
    while (done < 1500 && cycles < 40000) begin
      iv8 = ($urandom_range(0, 2) != 0);
      a8  = 8'($urandom);
      b8  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      if (iv8 && ir8) q.push_back(model(8, int'(a8), int'(b8)));
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL random_unexpected: result C=%0d REM=%0d with no operation pending",
                   c8, r8);
        end else begin
          e = q.pop_front();
          if (c8 !== 8'(e.c) || r8 !== 8'(e.rem) || z8 !== 1'(e.dbz)) begin
            errors++;
            $display("FAIL random_result: #%0d got C=%0d REM=%0d DBZ=%b, required %0d %0d %0d",
                     done, c8, r8, z8, e.c, e.rem, e.dbz);
          end
        end
        done++;
      end
      tick();
      cycles++;
    end
    iv8 = 1'b0; or8 = 1'b0;
    checks++;
    if (done < 1500) begin
      errors++;
      $display("FAIL random_progress: %0d results in %0d cycles, required 1500", done, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_by_zero();
    test_corners();
    test_stall();
    test_abort();
    test_width1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
